// File: rtl/fpu_issue_controller_if.sv
// Handshake bundle between the FPU issue controller, its requester/consumer and the fixed-point unit.
// The controller uses modport slave; the surrounding environment uses modport master.
interface fpu_issue_controller_if #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 5
);
    logic                 req_valid;
    logic                 req_ready;
    logic [WIDTH-1:0]     req_operand_1;
    logic [WIDTH-1:0]     req_operand_2;
    logic [1:0]           req_operation;
    logic [TAG_WIDTH-1:0] req_rd;

    logic [WIDTH-1:0]     fpu_operand_1;
    logic [WIDTH-1:0]     fpu_operand_2;
    logic [1:0]           fpu_operation;
    logic [WIDTH-1:0]     fpu_result;
    logic                 fpu_ready;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [WIDTH-1:0]     resp_result;
    logic [TAG_WIDTH-1:0] resp_rd;
    logic                 resp_error;

    modport slave (
        input  req_valid, req_operand_1, req_operand_2, req_operation, req_rd,
        output req_ready,
        output fpu_operand_1, fpu_operand_2, fpu_operation,
        input  fpu_result, fpu_ready,
        output resp_valid, resp_result, resp_rd, resp_error,
        input  resp_ready
    );

    modport master (
        output req_valid, req_operand_1, req_operand_2, req_operation, req_rd,
        input  req_ready,
        input  fpu_operand_1, fpu_operand_2, fpu_operation,
        output fpu_result, fpu_ready,
        input  resp_valid, resp_result, resp_rd, resp_error,
        output resp_ready
    );
endinterface

// File: rtl/fpu_issue_controller.sv
// Single-outstanding issue controller in front of a fixed-point unit (IDLE -> EXEC -> RESP).
// Optional EXEC watchdog enabled by defining FPU_TIMEOUT_EN.
module fpu_issue_controller #(
    parameter int WIDTH          = 32,
    parameter int TAG_WIDTH      = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    fpu_issue_controller_if.slave  bus
);
    localparam logic [1:0] FPU_ADD = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [WIDTH-1:0]     op1_q,    op1_d;
    logic [WIDTH-1:0]     op2_q,    op2_d;
    logic [1:0]           oper_q,   oper_d;
    logic [TAG_WIDTH-1:0] rd_q,     rd_d;
    logic [WIDTH-1:0]     result_q, result_d;

`ifdef FPU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 error_q,  error_d;
`endif

    // Next-state and datapath update; operands park to ADD/zero whenever the next state is not EXEC.
    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        oper_d   = oper_q;
        rd_d     = rd_q;
        result_d = result_q;
`ifdef FPU_TIMEOUT_EN
        cnt_d    = cnt_q;
        error_d  = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_EXEC;
                    op1_d   = bus.req_operand_1;
                    op2_d   = bus.req_operand_2;
                    oper_d  = bus.req_operation;
                    rd_d    = bus.req_rd;
`ifdef FPU_TIMEOUT_EN
                    cnt_d   = {CNT_W{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (bus.fpu_ready) begin
                    state_d  = ST_RESP;
                    result_d = bus.fpu_result;
`ifdef FPU_TIMEOUT_EN
                    error_d  = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = ST_RESP;
                    result_d = {WIDTH{1'b0}};
                    error_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    state_d  = ST_EXEC;
                end
`endif
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Park so that multi-cycle sequencers in the unit re-arm between operations.
        if (state_d != ST_EXEC) begin
            op1_d  = {WIDTH{1'b0}};
            op2_d  = {WIDTH{1'b0}};
            oper_d = FPU_ADD;
        end else begin
            oper_d = oper_d;
        end
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op1_q    <= {WIDTH{1'b0}};
            op2_q    <= {WIDTH{1'b0}};
            oper_q   <= FPU_ADD;
            rd_q     <= {TAG_WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
`ifdef FPU_TIMEOUT_EN
            cnt_q    <= {CNT_W{1'b0}};
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            oper_q   <= oper_d;
            rd_q     <= rd_d;
            result_q <= result_d;
`ifdef FPU_TIMEOUT_EN
            cnt_q    <= cnt_d;
            error_q  <= error_d;
`endif
        end
    end

    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.resp_valid    = (state_q == ST_RESP);
    assign bus.fpu_operand_1 = op1_q;
    assign bus.fpu_operand_2 = op2_q;
    assign bus.fpu_operation = oper_q;
    assign bus.resp_result   = result_q;
    assign bus.resp_rd       = rd_q;
`ifdef FPU_TIMEOUT_EN
    assign bus.resp_error    = error_q;
`else
    assign bus.resp_error    = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_controller.sv
// Directed bench for fpu_issue_controller with a behavioural fixed-point unit (Q.10 format).
module tb_fpu_issue_controller;
    localparam int W  = 32;
    localparam int TW = 5;
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_SQRT = 2'd3;
    // Unit model raises ready after 4 counted cycles, so MUL/SQRT spend 5 cycles in EXEC.
    localparam logic [3:0] SEQ_LAT  = 4'd4;
    localparam int         SEQ_EXEC = 5;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic         stub_ready;
    logic [3:0]   seq_cnt;
    logic [63:0]  wide;
    logic [W-1:0] model_result;

    fpu_issue_controller_if #(.WIDTH(W), .TAG_WIDTH(TW)) bus_if ();

    fpu_issue_controller #(.WIDTH(W), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] isqrt(input logic [63:0] x);
        logic [31:0] r;
        logic [31:0] t;
        r = 32'd0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if (({32'd0, t} * {32'd0, t}) <= x) r = t;
        end
        return r;
    endfunction

    always_comb begin
        wide = 64'd0;
        case (bus_if.fpu_operation)
            OP_ADD:  model_result = bus_if.fpu_operand_1 + bus_if.fpu_operand_2;
            OP_SUB:  model_result = bus_if.fpu_operand_1 - bus_if.fpu_operand_2;
            OP_MUL: begin
                wide = {32'd0, bus_if.fpu_operand_1} * {32'd0, bus_if.fpu_operand_2};
                model_result = wide[41:10];
            end
            default: begin
                wide = {22'd0, bus_if.fpu_operand_1, 10'd0};
                model_result = isqrt(wide);
            end
        endcase
    end

    always @(posedge clk) begin
        if (bus_if.fpu_operation == OP_MUL || bus_if.fpu_operation == OP_SQRT)
            seq_cnt <= (seq_cnt == 4'd15) ? seq_cnt : seq_cnt + 4'd1;
        else
            seq_cnt <= 4'd0;
    end

    assign bus_if.fpu_result = model_result;
    assign bus_if.fpu_ready  = stub_ready ? 1'b0 :
                               (bus_if.fpu_operation == OP_ADD || bus_if.fpu_operation == OP_SUB) ? 1'b1 :
                               (seq_cnt >= SEQ_LAT);

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] rd);
        bus_if.req_valid     = 1'b1;
        bus_if.req_operation = op;
        bus_if.req_operand_1 = a;
        bus_if.req_operand_2 = b;
        bus_if.req_rd        = rd;
        @(negedge clk);
        bus_if.req_valid     = 1'b0;
    endtask

    task automatic wait_resp(input int bound, output int k);
        k = 0;
        while (bus_if.resp_valid !== 1'b1 && k < bound) begin
            k++;
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        bus_if.resp_ready = 1'b1;
        @(negedge clk);
        bus_if.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus_if.req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_req_ready: got %b expected 1", bus_if.req_ready);
        end
        tests_run++;
        if ({bus_if.resp_valid, bus_if.resp_error} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_resp_flags: got %b expected 00", {bus_if.resp_valid, bus_if.resp_error});
        end
        tests_run++;
        if ({bus_if.resp_result, bus_if.resp_rd} !== 37'd0) begin
            tests_failed++; $display("FAIL reset_resp_data: got %h/%h expected 0/0", bus_if.resp_result, bus_if.resp_rd);
        end
        tests_run++;
        if ({bus_if.fpu_operation, bus_if.fpu_operand_1, bus_if.fpu_operand_2} !== {OP_ADD, 64'd0}) begin
            tests_failed++; $display("FAIL reset_park: got op %0d a %h b %h expected op 0 a 0 b 0",
                                     bus_if.fpu_operation, bus_if.fpu_operand_1, bus_if.fpu_operand_2);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        int k;
        issue(OP_ADD, 32'h0000_0600, 32'h0000_0800, 5'd7);
        tests_run++;
        if ({bus_if.req_ready, bus_if.fpu_operation, bus_if.fpu_operand_1, bus_if.fpu_operand_2}
            !== {1'b0, OP_ADD, 32'h0000_0600, 32'h0000_0800}) begin
            tests_failed++; $display("FAIL add_exec_drive: got rdy %b op %0d a %h b %h expected rdy 0 op 0 a 600 b 800",
                                     bus_if.req_ready, bus_if.fpu_operation, bus_if.fpu_operand_1, bus_if.fpu_operand_2);
        end
        wait_resp(20, k);
        tests_run++;
        if (k !== 1) begin
            tests_failed++; $display("FAIL add_latency: got %0d exec cycles expected 1", k);
        end
        tests_run++;
        if ({bus_if.resp_result, bus_if.resp_rd, bus_if.resp_error} !== {32'h0000_0E00, 5'd7, 1'b0}) begin
            tests_failed++; $display("FAIL add_resp: got %h rd %0d err %b expected e00 rd 7 err 0",
                                     bus_if.resp_result, bus_if.resp_rd, bus_if.resp_error);
        end
        tests_run++;
        if ({bus_if.fpu_operation, bus_if.fpu_operand_1, bus_if.fpu_operand_2} !== {OP_ADD, 64'd0}) begin
            tests_failed++; $display("FAIL add_resp_park: got op %0d a %h expected op 0 a 0",
                                     bus_if.fpu_operation, bus_if.fpu_operand_1);
        end
        handshake();
        tests_run++;
        if ({bus_if.resp_valid, bus_if.req_ready} !== 2'b01) begin
            tests_failed++; $display("FAIL add_return_idle: got vld/rdy %b expected 01", {bus_if.resp_valid, bus_if.req_ready});
        end
    endtask

    task automatic test_mul();
        int k;
        issue(OP_MUL, 32'h0000_0800, 32'h0000_0C00, 5'd3);
        k = 0;
        while (bus_if.resp_valid !== 1'b1 && k < 50) begin
            tests_run++;
            if ({bus_if.fpu_operation, bus_if.fpu_operand_1, bus_if.fpu_operand_2}
                !== {OP_MUL, 32'h0000_0800, 32'h0000_0C00}) begin
                tests_failed++; $display("FAIL mul_hold: cycle %0d got op %0d a %h b %h expected op 2 a 800 b c00",
                                         k, bus_if.fpu_operation, bus_if.fpu_operand_1, bus_if.fpu_operand_2);
            end
            k++;
            @(negedge clk);
        end
        tests_run++;
        if (k !== SEQ_EXEC) begin
            tests_failed++; $display("FAIL mul_latency: got %0d exec cycles expected %0d", k, SEQ_EXEC);
        end
        tests_run++;
        if ({bus_if.resp_result, bus_if.resp_rd, bus_if.resp_error} !== {32'h0000_1800, 5'd3, 1'b0}) begin
            tests_failed++; $display("FAIL mul_resp: got %h rd %0d err %b expected 1800 rd 3 err 0",
                                     bus_if.resp_result, bus_if.resp_rd, bus_if.resp_error);
        end
        handshake();
    endtask

    task automatic test_sqrt_pair();
        int k;
        issue(OP_SQRT, 32'h0000_1000, 32'h0000_0000, 5'd2);
        wait_resp(50, k);
        tests_run++;
        if (k !== SEQ_EXEC || bus_if.resp_result !== 32'h0000_0800 || bus_if.resp_rd !== 5'd2) begin
            tests_failed++; $display("FAIL sqrt1_resp: got cycles %0d res %h rd %0d expected 5 800 2",
                                     k, bus_if.resp_result, bus_if.resp_rd);
        end
        tests_run++;
        if ({bus_if.fpu_operation, bus_if.fpu_operand_1} !== {OP_ADD, 32'd0}) begin
            tests_failed++; $display("FAIL sqrt_between_park: got op %0d a %h expected op 0 a 0",
                                     bus_if.fpu_operation, bus_if.fpu_operand_1);
        end
        handshake();
        issue(OP_SQRT, 32'h0000_2400, 32'h0000_0000, 5'd4);
        wait_resp(50, k);
        tests_run++;
        if (k !== SEQ_EXEC) begin
            tests_failed++; $display("FAIL sqrt2_latency: got %0d exec cycles expected %0d", k, SEQ_EXEC);
        end
        tests_run++;
        if ({bus_if.resp_result, bus_if.resp_rd} !== {32'h0000_0C00, 5'd4}) begin
            tests_failed++; $display("FAIL sqrt2_resp: got %h rd %0d expected c00 rd 4", bus_if.resp_result, bus_if.resp_rd);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int k;
        bus_if.resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus_if.resp_valid, bus_if.req_ready} !== 2'b01) begin
            tests_failed++; $display("FAIL idle_resp_ready: got vld/rdy %b expected 01", {bus_if.resp_valid, bus_if.req_ready});
        end
        bus_if.resp_ready = 1'b0;
        issue(OP_ADD, 32'h0000_0400, 32'h0000_0400, 5'd9);
        wait_resp(20, k);
        bus_if.req_valid     = 1'b1;
        bus_if.req_operation = OP_SUB;
        bus_if.req_operand_1 = 32'h0000_0800;
        bus_if.req_operand_2 = 32'h0000_0600;
        bus_if.req_rd        = 5'd1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({bus_if.resp_valid, bus_if.req_ready, bus_if.resp_rd, bus_if.resp_result}
                !== {1'b1, 1'b0, 5'd9, 32'h0000_0800}) begin
                tests_failed++; $display("FAIL stall_hold: cycle %0d got vld %b rdy %b rd %0d res %h expected 1 0 9 800",
                                         i, bus_if.resp_valid, bus_if.req_ready, bus_if.resp_rd, bus_if.resp_result);
            end
            @(negedge clk);
        end
        bus_if.resp_ready = 1'b1;
        @(negedge clk);
        bus_if.resp_ready = 1'b0;
        tests_run++;
        if ({bus_if.resp_valid, bus_if.req_ready} !== 2'b01) begin
            tests_failed++; $display("FAIL stall_release: got vld/rdy %b expected 01", {bus_if.resp_valid, bus_if.req_ready});
        end
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        tests_run++;
        if ({bus_if.fpu_operation, bus_if.fpu_operand_1} !== {OP_SUB, 32'h0000_0800}) begin
            tests_failed++; $display("FAIL stall_next_accept: got op %0d a %h expected op 1 a 800",
                                     bus_if.fpu_operation, bus_if.fpu_operand_1);
        end
        wait_resp(20, k);
        tests_run++;
        if (k !== 1 || {bus_if.resp_result, bus_if.resp_rd} !== {32'h0000_0200, 5'd1}) begin
            tests_failed++; $display("FAIL stall_next_resp: got cycles %0d res %h rd %0d expected 1 200 1",
                                     k, bus_if.resp_result, bus_if.resp_rd);
        end
        handshake();
    endtask

    task automatic test_reset_mid_exec();
        logic seen;
        issue(OP_MUL, 32'h0000_0800, 32'h0000_0C00, 5'd6);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if ({bus_if.req_ready, bus_if.resp_valid, bus_if.fpu_operation, bus_if.resp_rd} !== {1'b1, 1'b0, OP_ADD, 5'd0}) begin
            tests_failed++; $display("FAIL midexec_reset: got rdy %b vld %b op %0d rd %0d expected 1 0 0 0",
                                     bus_if.req_ready, bus_if.resp_valid, bus_if.fpu_operation, bus_if.resp_rd);
        end
        seen = 1'b0;
        repeat (8) begin
            if (bus_if.resp_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++; $display("FAIL midexec_no_resp: got resp seen %b expected 0", seen);
        end
    endtask

    task automatic test_stalled_unit();
        int k;
        stub_ready = 1'b1;
        issue(OP_MUL, 32'h0000_0800, 32'h0000_0C00, 5'd5);
`ifdef FPU_TIMEOUT_EN
        wait_resp(200, k);
        tests_run++;
        if (k !== 64) begin
            tests_failed++; $display("FAIL timeout_cycles: got %0d exec cycles expected 64", k);
        end
        tests_run++;
        if ({bus_if.resp_valid, bus_if.resp_error, bus_if.resp_result, bus_if.resp_rd} !== {1'b1, 1'b1, 32'd0, 5'd5}) begin
            tests_failed++; $display("FAIL timeout_resp: got vld %b err %b res %h rd %0d expected 1 1 0 5",
                                     bus_if.resp_valid, bus_if.resp_error, bus_if.resp_result, bus_if.resp_rd);
        end
        stub_ready = 1'b0;
        handshake();
`else
        k = 0;
        repeat (100) @(negedge clk);
        tests_run++;
        if ({bus_if.resp_valid, bus_if.req_ready, bus_if.resp_error} !== 3'b000) begin
            tests_failed++; $display("FAIL wait_forever: got vld/rdy/err %b expected 000",
                                     {bus_if.resp_valid, bus_if.req_ready, bus_if.resp_error});
        end
        stub_ready = 1'b0;
        wait_resp(20, k);
        tests_run++;
        if (k !== 1 || {bus_if.resp_result, bus_if.resp_error} !== {32'h0000_1800, 1'b0}) begin
            tests_failed++; $display("FAIL late_ready_resp: got cycles %0d res %h err %b expected 1 1800 0",
                                     k, bus_if.resp_result, bus_if.resp_error);
        end
        handshake();
`endif
    endtask

    task automatic test_back_to_back();
        int k;
        issue(OP_SUB, 32'h0000_0800, 32'h0000_0600, 5'd1);
        wait_resp(20, k);
        tests_run++;
        if (k !== 1 || {bus_if.resp_result, bus_if.resp_error} !== {32'h0000_0200, 1'b0}) begin
            tests_failed++; $display("FAIL b2b_sub: got cycles %0d res %h err %b expected 1 200 0",
                                     k, bus_if.resp_result, bus_if.resp_error);
        end
        handshake();
        issue(OP_ADD, 32'h7FFF_FC00, 32'h0000_0400, 5'd31);
        wait_resp(20, k);
        tests_run++;
        if (k !== 1 || {bus_if.resp_result, bus_if.resp_rd} !== {32'h8000_0000, 5'd31}) begin
            tests_failed++; $display("FAIL b2b_add: got cycles %0d res %h rd %0d expected 1 80000000 31",
                                     k, bus_if.resp_result, bus_if.resp_rd);
        end
        handshake();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        reset                = 1'b1;
        stub_ready           = 1'b0;
        bus_if.req_valid     = 1'b0;
        bus_if.req_operation = OP_ADD;
        bus_if.req_operand_1 = 32'd0;
        bus_if.req_operand_2 = 32'd0;
        bus_if.req_rd        = 5'd0;
        bus_if.resp_ready    = 1'b0;
        test_reset();
        test_add();
        test_mul();
        test_sqrt_pair();
        test_backpressure();
        test_reset_mid_exec();
        test_stalled_unit();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
